// File: rtl/judge_hp_unit.sv
// Judge and HP keeper for the factorization game: latches N = Q_A*Q_B at ARM,
// checks factor-pair answers from two players, and tracks each player's HP.
module judge_hp_unit #(
    parameter int DATA_W      = 8,
    parameter int HP_INIT     = 3,
    parameter int LOCK_CYCLES = 50000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Q_VALID,
    input  logic [DATA_W-1:0] Q_A,
    input  logic [DATA_W-1:0] Q_B,
    input  logic              ARM,
    input  logic              ABORT,
    input  logic              ACK,
    input  logic              NEW_GAME,
    input  logic              P1_SUB,
    input  logic [DATA_W-1:0] P1_X,
    input  logic [DATA_W-1:0] P1_Y,
    input  logic              P2_SUB,
    input  logic [DATA_W-1:0] P2_X,
    input  logic [DATA_W-1:0] P2_Y,
    output logic [1:0]        JUDG,
    output logic              JUDG_VALID,
    output logic              WRONG,
    output logic [1:0]        WRONG_WHO,
    output logic [3:0]        HP1,
    output logic [3:0]        HP2,
    output logic [1:0]        HP_STAT,
    output logic              BUSY
);
    // state  | meaning
    // IDLE   | no round open; NEW_GAME and ARM honoured
    // ARMED  | round open, waiting for submissions
    // CHECK  | one cycle: judge the pending answers
    // RESULT | correct answer reported, held until ACK
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    localparam int PW     = 2 * DATA_W;
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [PW-1:0]     r_n;
    logic [DATA_W-1:0] r_p1x, r_p1y, r_p2x, r_p2y;
    logic              r_p1_pend, r_p2_pend;
    logic [LOCK_W-1:0] r_lock1, r_lock2;
    logic [1:0]        r_judg;
    logic              r_judg_valid;
    logic              r_wrong;
    logic [1:0]        r_wrong_who;
    logic [3:0]        r_hp1, r_hp2;
    logic [1:0]        r_hp_stat;
    logic              r_busy;

    logic              w_acc1, w_acc2;
    logic              w_ok1, w_ok2, w_any_ok;
    logic              w_judge;
    logic [PW-1:0]     w_prod1, w_prod2;

    // Operand order needs no special handling: the product is commutative.
    assign w_prod1 = PW'(r_p1x) * PW'(r_p1y);
    assign w_prod2 = PW'(r_p2x) * PW'(r_p2y);
    assign w_ok1   = r_p1_pend && (r_p1x >= DATA_W'(2)) && (r_p1y >= DATA_W'(2)) && (w_prod1 == r_n);
    assign w_ok2   = r_p2_pend && (r_p2x >= DATA_W'(2)) && (r_p2y >= DATA_W'(2)) && (w_prod2 == r_n);
    assign w_any_ok = w_ok1 || w_ok2;

    assign w_acc1  = (r_state == ARMED) && !ABORT && P1_SUB && (r_lock1 == '0);
    assign w_acc2  = (r_state == ARMED) && !ABORT && P2_SUB && (r_lock2 == '0);
    assign w_judge = (r_state == CHECK) && !ABORT;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ARM && Q_VALID) w_state_nxt = ARMED;
            ARMED:   if (ABORT) w_state_nxt = IDLE;
                     else if (w_acc1 || w_acc2) w_state_nxt = CHECK;
            CHECK:   if (ABORT) w_state_nxt = IDLE;
                     else if (w_any_ok) w_state_nxt = RESULT;
                     else w_state_nxt = ARMED;
            RESULT:  if (ACK) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_n          <= '0;
            r_p1x        <= '0;
            r_p1y        <= '0;
            r_p2x        <= '0;
            r_p2y        <= '0;
            r_p1_pend    <= 1'b0;
            r_p2_pend    <= 1'b0;
            r_lock1      <= '0;
            r_lock2      <= '0;
            r_judg       <= 2'b00;
            r_judg_valid <= 1'b0;
            r_wrong      <= 1'b0;
            r_wrong_who  <= 2'b00;
            r_hp1        <= 4'(HP_INIT);
            r_hp2        <= 4'(HP_INIT);
            r_hp_stat    <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_wrong   <= 1'b0;
            r_hp_stat <= {(r_hp1 == 4'd0), (r_hp2 == 4'd0)};

            if (r_state == IDLE && ARM && Q_VALID)
                r_n <= PW'(Q_A) * PW'(Q_B);

            if (w_acc1) begin
                r_p1x     <= P1_X;
                r_p1y     <= P1_Y;
                r_p1_pend <= 1'b1;
            end
            if (w_acc2) begin
                r_p2x     <= P2_X;
                r_p2y     <= P2_Y;
                r_p2_pend <= 1'b1;
            end
            if (r_state == CHECK || (r_state == ARMED && ABORT)) begin
                r_p1_pend <= 1'b0;
                r_p2_pend <= 1'b0;
            end

            // A wrong answer only counts when nobody got it right this check.
            if (w_judge && !w_any_ok && r_p1_pend) r_lock1 <= LOCK_W'(LOCK_CYCLES);
            else if (r_lock1 != '0)                r_lock1 <= r_lock1 - LOCK_W'(1);
            if (w_judge && !w_any_ok && r_p2_pend) r_lock2 <= LOCK_W'(LOCK_CYCLES);
            else if (r_lock2 != '0)                r_lock2 <= r_lock2 - LOCK_W'(1);

            if (w_judge && !w_any_ok) begin
                r_wrong     <= 1'b1;
                r_wrong_who <= {r_p2_pend, r_p1_pend};
            end

            if (w_judge && w_any_ok) begin
                r_judg       <= {w_ok2, w_ok1};
                r_judg_valid <= 1'b1;
                if (w_ok1) r_hp2 <= (r_hp2 != 4'd0) ? r_hp2 - 4'd1 : 4'd0;
                if (w_ok2) r_hp1 <= (r_hp1 != 4'd0) ? r_hp1 - 4'd1 : 4'd0;
            end else if (r_state == RESULT && ACK) begin
                r_judg       <= 2'b00;
                r_judg_valid <= 1'b0;
            end

            if (r_state == IDLE && NEW_GAME) begin
                r_hp1 <= 4'(HP_INIT);
                r_hp2 <= 4'(HP_INIT);
            end
        end
    end

    assign JUDG       = r_judg;
    assign JUDG_VALID = r_judg_valid;
    assign WRONG      = r_wrong;
    assign WRONG_WHO  = r_wrong_who;
    assign HP1        = r_hp1;
    assign HP2        = r_hp2;
    assign HP_STAT    = r_hp_stat;
    assign BUSY       = r_busy;
endmodule

// File: tb/tb_judge_hp_unit.sv
// Directed bench for judge_hp_unit: rounds, wrong-answer lockout, HP saturation,
// abort and asynchronous reset, with hand-computed expectations.
module tb_judge_hp_unit;
    logic       CLK = 1'b0;
    logic       RST;
    logic       Q_VALID, ARM, ABORT, ACK, NEW_GAME, P1_SUB, P2_SUB;
    logic [7:0] Q_A, Q_B, P1_X, P1_Y, P2_X, P2_Y;
    logic [1:0] JUDG, WRONG_WHO, HP_STAT;
    logic       JUDG_VALID, WRONG, BUSY;
    logic [3:0] HP1, HP2;

    int total = 0;
    int bad   = 0;

    judge_hp_unit #(.DATA_W(8), .HP_INIT(3), .LOCK_CYCLES(8)) dut (
        .CLK(CLK), .RST(RST), .Q_VALID(Q_VALID), .Q_A(Q_A), .Q_B(Q_B),
        .ARM(ARM), .ABORT(ABORT), .ACK(ACK), .NEW_GAME(NEW_GAME),
        .P1_SUB(P1_SUB), .P1_X(P1_X), .P1_Y(P1_Y),
        .P2_SUB(P2_SUB), .P2_X(P2_X), .P2_Y(P2_Y),
        .JUDG(JUDG), .JUDG_VALID(JUDG_VALID), .WRONG(WRONG), .WRONG_WHO(WRONG_WHO),
        .HP1(HP1), .HP2(HP2), .HP_STAT(HP_STAT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic arm(input int a, input int b);
        Q_A = 8'(a); Q_B = 8'(b); Q_VALID = 1'b1; ARM = 1'b1;
        tick;
        ARM = 1'b0; Q_VALID = 1'b0;
    endtask

    task automatic sub(input bit s1, input int x1, input int y1,
                       input bit s2, input int x2, input int y2);
        P1_SUB = s1; P1_X = 8'(x1); P1_Y = 8'(y1);
        P2_SUB = s2; P2_X = 8'(x2); P2_Y = 8'(y2);
        tick;
        P1_SUB = 1'b0; P2_SUB = 1'b0;
    endtask

    task automatic ack;
        ACK = 1'b1;
        tick;
        ACK = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        {Q_VALID, ARM, ABORT, ACK, NEW_GAME, P1_SUB, P2_SUB} = '0;
        {Q_A, Q_B, P1_X, P1_Y, P2_X, P2_Y} = '0;
        #12;
        chk("rst_hp1", int'(HP1), 3);
        chk("rst_hp2", int'(HP2), 3);
        chk("rst_jv", int'(JUDG_VALID), 0);
        chk("rst_busy", int'(BUSY), 0);
        RST = 1'b0;
        tick;

        NEW_GAME = 1'b1; tick; NEW_GAME = 1'b0;
        chk("ng_hp1", int'(HP1), 3);
        chk("ng_hp2", int'(HP2), 3);
        chk("ng_stat", int'(HP_STAT), 0);
        chk("ng_busy", int'(BUSY), 0);

        ARM = 1'b1; tick; ARM = 1'b0;
        chk("arm_noq_busy", int'(BUSY), 0);

        // Round 1: P1 answers reversed order; Q changes after ARM must not matter.
        arm(7, 11);
        chk("r1_busy", int'(BUSY), 1);
        Q_A = 8'd5; Q_B = 8'd5;
        sub(1, 11, 7, 0, 0, 0);
        chk("r1_t1_jv", int'(JUDG_VALID), 0);
        tick;
        chk("r1_judg", int'(JUDG), 1);
        chk("r1_jv", int'(JUDG_VALID), 1);
        chk("r1_hp2", int'(HP2), 2);
        chk("r1_hp1", int'(HP1), 3);
        tick;
        chk("r1_hold", int'(JUDG_VALID), 1);
        ack;
        chk("r1_ack_jv", int'(JUDG_VALID), 0);
        chk("r1_ack_judg", int'(JUDG), 0);
        chk("r1_ack_busy", int'(BUSY), 0);

        // Round 2: P1 trivial factor (1,77) is wrong but suppressed by P2 correct.
        arm(7, 11);
        sub(1, 1, 77, 1, 7, 11);
        tick;
        chk("r2_judg", int'(JUDG), 2);
        chk("r2_wrong", int'(WRONG), 0);
        chk("r2_hp1", int'(HP1), 2);
        chk("r2_hp2", int'(HP2), 2);
        ack;

        // Round 3: P2 wrong, locked out; P1 then wins.
        arm(7, 11);
        sub(0, 0, 0, 1, 7, 12);
        tick;
        chk("r3_wrong", int'(WRONG), 1);
        chk("r3_who", int'(WRONG_WHO), 2);
        chk("r3_jv", int'(JUDG_VALID), 0);
        chk("r3_busy", int'(BUSY), 1);
        NEW_GAME = 1'b1; tick; NEW_GAME = 1'b0;
        chk("r3_wrong_pulse", int'(WRONG), 0);
        chk("r3_ng_ignored", int'(HP1), 2);
        sub(0, 0, 0, 1, 7, 11);
        tick;
        chk("r3_locked_jv", int'(JUDG_VALID), 0);
        chk("r3_locked_wrong", int'(WRONG), 0);
        sub(1, 7, 11, 0, 0, 0);
        tick;
        chk("r3_judg", int'(JUDG), 1);
        chk("r3_hp2", int'(HP2), 1);
        ack;
        repeat (4) tick;

        // Both players correct each round from full HP; HP saturates at zero.
        NEW_GAME = 1'b1; tick; NEW_GAME = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            arm(7, 11);
            sub(1, 7, 11, 1, 11, 7);
            tick;
            chk("both_judg", int'(JUDG), 3);
            chk("both_hp1", int'(HP1), (r >= 3) ? 0 : 3 - r);
            chk("both_hp2", int'(HP2), (r >= 3) ? 0 : 3 - r);
            tick;
            chk("both_stat", int'(HP_STAT), (r >= 3) ? 3 : 0);
            ack;
        end

        // Abort with same-cycle submit.
        NEW_GAME = 1'b1; tick; NEW_GAME = 1'b0;
        arm(7, 11);
        ABORT = 1'b1;
        sub(1, 7, 11, 0, 0, 0);
        ABORT = 1'b0;
        chk("abort_busy", int'(BUSY), 0);
        tick;
        chk("abort_jv", int'(JUDG_VALID), 0);
        chk("abort_hp2", int'(HP2), 3);

        // Asynchronous reset while in RESULT.
        arm(7, 11);
        sub(1, 7, 11, 0, 0, 0);
        tick;
        chk("pre_rst_jv", int'(JUDG_VALID), 1);
        chk("pre_rst_hp2", int'(HP2), 2);
        #2 RST = 1'b1;
        #1;
        chk("arst_jv", int'(JUDG_VALID), 0);
        chk("arst_judg", int'(JUDG), 0);
        chk("arst_busy", int'(BUSY), 0);
        chk("arst_hp2", int'(HP2), 3);
        chk("arst_stat", int'(HP_STAT), 0);
        #2 RST = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
